tri_raster_engine: RTL
======================

// Module: tri_raster_engine
// PURPOSE
//  Self-sequenced edge-function triangle rasterizer. Replaces manual per-phase
//  strobes with an internal FSM and valid/ready handshakes on triangle input and
//  fragment output. Sits between vertex screen-space setup and the depth/frame writer.
//  Generalised in coordinate/depth/colour width, screen clip size and depth mode.
// PARAMETERS
//  COORD_W    16   signed two's-complement vertex/pixel coordinate width
//  DEPTH_W    2    per-vertex and per-fragment depth width
//  COLOR_W    16   flat triangle colour width (ARGB)
//  SCREEN_W   640  horizontal clip limit; x emitted in [0, SCREEN_W-1]
//  SCREEN_H   480  vertical clip limit; y emitted in [0, SCREEN_H-1]
//  DEPTH_MODE 0    0 = fragment depth is v0 depth; 1 = min of the three depths
// PORTS
//  clock              in   1        rising-edge clock
//  reset              in   1        asynchronous, active-high
//  in_tri_valid       in   1        triangle fields valid
//  out_tri_ready      out  1        engine idle, can accept a triangle
//  in_v{0,1,2}_x/_y   in   COORD_W  vertex screen coords (signed)
//  in_v{0,1,2}_depth  in   DEPTH_W  vertex depths
//  in_color           in   COLOR_W  flat colour
//  out_pixel_valid    out  1        fragment outputs valid
//  in_pixel_ready     in   1        downstream accepts fragment
//  out_pixel_x/_y     out  COORD_W  fragment coordinates
//  out_pixel_depth    out  DEPTH_W  fragment depth
//  out_pixel_color    out  COLOR_W  fragment colour
//  out_busy           out  1        high in any state other than IDLE
//  out_done           out  1        one-cycle pulse: triangle fully rasterized
// BEHAVIOUR
//  Reset: FSM->IDLE; out_pixel_valid, out_busy, out_done = 0; pixel x/y/depth/color = 0;
//   out_tri_ready = 1 once reset deasserts. Reset mid-scan drops the triangle silently.
//  Accept: in_tri_valid & out_tri_ready at edge T latches all inputs; out_tri_ready
//   is high only in IDLE (combinational from state).
//  FSM: IDLE -> BBOX (T+1) -> EDGES (T+2) -> SETUP (T+3) -> SCAN -> DONE -> IDLE.
//   BBOX: min/max of vertex x,y, clamped to [0,SCREEN_W-1] x [0,SCREEN_H-1]; if the
//    box is empty after clamping, go straight to DONE.
//   EDGES: per edge i (v0v1, v1v2, v2v0): A=ya-yb, B=xb-xa, C=xa*yb-xb*ya, signed,
//    width 2*COORD_W+2; area = sum of the three C. Area == 0 (degenerate) -> DONE.
//   SETUP: load scan position (xmin,ymin) and E_i at that point.
//   SCAN: row-major, x fastest; one candidate pixel per cycle. Inside test is
//    inclusive: all E_i >= 0 when area > 0, all E_i <= 0 when area < 0 (either
//    winding). Stepping is incremental: E_i += A_i per x, row restart += B_i.
//    Inside pixel at cycle n -> out_pixel_* registered, valid from n+1.
//    Stall: while out_pixel_valid & !in_pixel_ready, scan and all outputs hold.
//    Valid drops the cycle after the handshake unless the next pixel is inside.
//   DONE: entered after the last box pixel is evaluated and its fragment (if any)
//    is accepted; out_done = 1 for exactly this cycle; next state IDLE.
//  Depth: DEPTH_MODE 0 -> v0 depth; 1 -> unsigned min(v0,v1,v2). Colour is flat.
//  Shared edges are emitted by both triangles (no tie-break rule); accepted.
// TESTING
//  1 tri (100,25),(103,29),(97,29), ready=1 -> 17 fragments: rows y25..29 give 1,1,3,5,7;
//    first (100,25), last (103,29); colour FF00; out_done once after the 17th.
//  2 same tri with v1/v2 swapped -> identical 17 fragments in the same order.
//  3 (630,470),(700,470),(630,500), 640x480 -> exactly 100 fragments, x 630..639,
//    y 470..479; none with x>639 or y>479.
//  4 collinear (0,0),(5,5),(10,10) -> no out_pixel_valid; out_done 4 cycles after accept.
//  5 test 1 with in_pixel_ready low 5 cycles at the 1st fragment -> (100,25) held stable;
//    total count still 17; DEPTH_MODE=1 with depths 0,3,2 -> depth 0 on every fragment.
//  6 assert reset during the 3rd fragment -> all outputs 0 and out_tri_ready=1 next cycle;
//    re-submitting test 1 then yields all 17 fragments.

Source files
------------

// File: rtl/tri_raster_engine_if.sv
// tri_raster_engine_if
//   Triangle-in / fragment-out bus for tri_raster_engine.
//   slave  : engine side   (samples in_*, drives out_*)
//   master : upstream vertex setup + downstream depth/frame writer side
//   Triangle channel : in_tri_valid / out_tri_ready, three signed vertices,
//                      per-vertex depth, flat colour.
//   Fragment channel : out_pixel_valid / in_pixel_ready, x/y/depth/colour.
//   Status           : out_busy (not idle), out_done (one-cycle end-of-triangle).
interface tri_raster_engine_if #(
   parameter int COORD_W = 16,
   parameter int DEPTH_W = 2,
   parameter int COLOR_W = 16
);
   logic                      in_tri_valid;
   logic                      out_tri_ready;
   logic signed [COORD_W-1:0] in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y;
   logic [DEPTH_W-1:0]        in_v0_depth, in_v1_depth, in_v2_depth;
   logic [COLOR_W-1:0]        in_color;
   logic                      out_pixel_valid;
   logic                      in_pixel_ready;
   logic signed [COORD_W-1:0] out_pixel_x, out_pixel_y;
   logic [DEPTH_W-1:0]        out_pixel_depth;
   logic [COLOR_W-1:0]        out_pixel_color;
   logic                      out_busy;
   logic                      out_done;

   modport slave (
      input  in_tri_valid, in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y,
             in_v0_depth, in_v1_depth, in_v2_depth, in_color, in_pixel_ready,
      output out_tri_ready, out_pixel_valid, out_pixel_x, out_pixel_y,
             out_pixel_depth, out_pixel_color, out_busy, out_done
   );

   modport master (
      output in_tri_valid, in_v0_x, in_v0_y, in_v1_x, in_v1_y, in_v2_x, in_v2_y,
             in_v0_depth, in_v1_depth, in_v2_depth, in_color, in_pixel_ready,
      input  out_tri_ready, out_pixel_valid, out_pixel_x, out_pixel_y,
             out_pixel_depth, out_pixel_color, out_busy, out_done
   );
endinterface

// File: rtl/tri_raster_engine.sv
// tri_raster_engine
//   Edge-function triangle rasterizer. Accepts one triangle when idle, computes a
//   screen-clamped bounding box and three edge functions, then walks the box
//   row-major (x fastest), one candidate pixel per cycle, emitting inside pixels
//   as registered fragments with valid/ready backpressure.
//   Ports:
//     clock, reset : rising-edge clock, asynchronous active-high reset
//     bus          : tri_raster_engine_if.slave (triangle in, fragment out, status)
module tri_raster_engine #(
   parameter int COORD_W    = 16,
   parameter int DEPTH_W    = 2,
   parameter int COLOR_W    = 16,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int DEPTH_MODE = 0
) (
   input logic                clock,
   input logic                reset,
   tri_raster_engine_if.slave bus
);
   localparam int EW = 2*COORD_W + 2;
   localparam logic signed [COORD_W-1:0] XCLIP = COORD_W'(SCREEN_W - 1);
   localparam logic signed [COORD_W-1:0] YCLIP = COORD_W'(SCREEN_H - 1);

   typedef enum logic [2:0] {S_IDLE, S_BBOX, S_EDGES, S_SETUP, S_SCAN, S_DONE} state_t;

   function automatic logic signed [EW-1:0] sx(input logic signed [COORD_W-1:0] v);
      return {{(EW-COORD_W){v[COORD_W-1]}}, v};
   endfunction

   state_t                    r_state;
   logic signed [COORD_W-1:0] r_vx [3];
   logic signed [COORD_W-1:0] r_vy [3];
   logic [DEPTH_W-1:0]        r_depth;
   logic [COLOR_W-1:0]        r_color;
   logic signed [COORD_W-1:0] r_xmin, r_xmax, r_ymin, r_ymax, r_x, r_y;
   logic signed [EW-1:0]      r_a [3];
   logic signed [EW-1:0]      r_b [3];
   logic signed [EW-1:0]      r_c [3];
   logic signed [EW-1:0]      r_e [3];     // edge values at current scan pixel
   logic signed [EW-1:0]      r_erow [3];  // edge values at start of current row
   logic signed [EW-1:0]      r_area;
   logic                      r_end;       // last box pixel already evaluated
   logic                      r_pix_valid, r_busy, r_done;
   logic signed [COORD_W-1:0] r_pix_x, r_pix_y;
   logic [DEPTH_W-1:0]        r_pix_depth;
   logic [COLOR_W-1:0]        r_pix_color;

   logic signed [COORD_W-1:0] w_xlo, w_xhi, w_ylo, w_yhi, w_xmin, w_xmax, w_ymin, w_ymax;
   logic                      w_empty, w_pos, w_neg, w_in, w_adv;
   logic [DEPTH_W-1:0]        w_dmin, w_dsel;
   logic signed [EW-1:0]      w_sx [3];
   logic signed [EW-1:0]      w_sy [3];
   logic signed [EW-1:0]      w_a [3];
   logic signed [EW-1:0]      w_b [3];
   logic signed [EW-1:0]      w_c [3];
   logic signed [EW-1:0]      w_e0 [3];

   always_comb begin
      // Bounding box of the latched vertices, clamped to the screen.
      w_xlo = r_vx[0]; w_xhi = r_vx[0]; w_ylo = r_vy[0]; w_yhi = r_vy[0];
      for (int i = 1; i < 3; i++) begin
         if (r_vx[i] < w_xlo) w_xlo = r_vx[i];
         if (r_vx[i] > w_xhi) w_xhi = r_vx[i];
         if (r_vy[i] < w_ylo) w_ylo = r_vy[i];
         if (r_vy[i] > w_yhi) w_yhi = r_vy[i];
      end
      w_xmin  = w_xlo[COORD_W-1] ? '0 : w_xlo;
      w_ymin  = w_ylo[COORD_W-1] ? '0 : w_ylo;
      w_xmax  = (w_xhi > XCLIP) ? XCLIP : w_xhi;
      w_ymax  = (w_yhi > YCLIP) ? YCLIP : w_yhi;
      w_empty = (w_xmin > w_xmax) || (w_ymin > w_ymax);

      // Edge i runs from vertex i to vertex (i+1)%3.
      for (int i = 0; i < 3; i++) begin
         w_sx[i] = sx(r_vx[i]);
         w_sy[i] = sx(r_vy[i]);
      end
      w_a[0] = w_sy[0] - w_sy[1];  w_b[0] = w_sx[1] - w_sx[0];
      w_a[1] = w_sy[1] - w_sy[2];  w_b[1] = w_sx[2] - w_sx[1];
      w_a[2] = w_sy[2] - w_sy[0];  w_b[2] = w_sx[0] - w_sx[2];
      w_c[0] = w_sx[0]*w_sy[1] - w_sx[1]*w_sy[0];
      w_c[1] = w_sx[1]*w_sy[2] - w_sx[2]*w_sy[1];
      w_c[2] = w_sx[2]*w_sy[0] - w_sx[0]*w_sy[2];

      // Edge values at the box origin, plus the inclusive winding-agnostic test.
      w_pos = 1'b1;
      w_neg = 1'b1;
      for (int i = 0; i < 3; i++) begin
         w_e0[i] = r_a[i]*sx(r_xmin) + r_b[i]*sx(r_ymin) + r_c[i];
         if (r_e[i][EW-1]) w_pos = 1'b0;
         if (!r_e[i][EW-1] && (r_e[i] != '0)) w_neg = 1'b0;
      end
      w_in  = r_area[EW-1] ? w_neg : w_pos;
      w_adv = !r_pix_valid || bus.in_pixel_ready;

      w_dmin = bus.in_v0_depth;
      if (bus.in_v1_depth < w_dmin) w_dmin = bus.in_v1_depth;
      if (bus.in_v2_depth < w_dmin) w_dmin = bus.in_v2_depth;
      w_dsel = (DEPTH_MODE == 1) ? w_dmin : bus.in_v0_depth;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_depth     <= '0;
         r_color     <= '0;
         r_xmin      <= '0;
         r_xmax      <= '0;
         r_ymin      <= '0;
         r_ymax      <= '0;
         r_x         <= '0;
         r_y         <= '0;
         r_area      <= '0;
         r_end       <= 1'b0;
         r_pix_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_pix_depth <= '0;
         r_pix_color <= '0;
         for (int i = 0; i < 3; i++) begin
            r_vx[i] <= '0; r_vy[i] <= '0;
            r_a[i]  <= '0; r_b[i]  <= '0; r_c[i] <= '0;
            r_e[i]  <= '0; r_erow[i] <= '0;
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: if (bus.in_tri_valid) begin
               r_vx[0] <= bus.in_v0_x; r_vy[0] <= bus.in_v0_y;
               r_vx[1] <= bus.in_v1_x; r_vy[1] <= bus.in_v1_y;
               r_vx[2] <= bus.in_v2_x; r_vy[2] <= bus.in_v2_y;
               r_depth <= w_dsel;
               r_color <= bus.in_color;
               r_busy  <= 1'b1;
               r_state <= S_BBOX;
            end
            S_BBOX: begin
               r_xmin <= w_xmin; r_xmax <= w_xmax;
               r_ymin <= w_ymin; r_ymax <= w_ymax;
               r_done  <= w_empty;
               r_state <= w_empty ? S_DONE : S_EDGES;
            end
            S_EDGES: begin
               for (int i = 0; i < 3; i++) begin
                  r_a[i] <= w_a[i]; r_b[i] <= w_b[i]; r_c[i] <= w_c[i];
               end
               r_area  <= w_c[0] + w_c[1] + w_c[2];
               r_state <= S_SETUP;
            end
            // Degenerate triangles are rejected here, once the area is registered.
            S_SETUP: if (r_area == '0) begin
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end else begin
               for (int i = 0; i < 3; i++) begin
                  r_e[i] <= w_e0[i]; r_erow[i] <= w_e0[i];
               end
               r_x     <= r_xmin;
               r_y     <= r_ymin;
               r_end   <= 1'b0;
               r_state <= S_SCAN;
            end
            // Everything holds while a fragment is presented but not taken.
            S_SCAN: if (w_adv) begin
               if (r_end) begin
                  r_pix_valid <= 1'b0;
                  r_done      <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_pix_valid <= w_in;
                  if (w_in) begin
                     r_pix_x     <= r_x;
                     r_pix_y     <= r_y;
                     r_pix_depth <= r_depth;
                     r_pix_color <= r_color;
                  end
                  if (r_x != r_xmax) begin
                     r_x <= r_x + 1'b1;
                     for (int i = 0; i < 3; i++) r_e[i] <= r_e[i] + r_a[i];
                  end else if (r_y != r_ymax) begin
                     r_x <= r_xmin;
                     r_y <= r_y + 1'b1;
                     for (int i = 0; i < 3; i++) begin
                        r_erow[i] <= r_erow[i] + r_b[i];
                        r_e[i]    <= r_erow[i] + r_b[i];
                     end
                  end else begin
                     r_end <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.out_tri_ready   = (r_state == S_IDLE);
   assign bus.out_pixel_valid = r_pix_valid;
   assign bus.out_pixel_x     = r_pix_x;
   assign bus.out_pixel_y     = r_pix_y;
   assign bus.out_pixel_depth = r_pix_depth;
   assign bus.out_pixel_color = r_pix_color;
   assign bus.out_busy        = r_busy;
   assign bus.out_done        = r_done;
endmodule
